// File: rtl/forward_ctrl.sv
// Forwarding and load-use hazard control for a 5-stage LEGv8 pipeline.
// Latency: operand selects and stall are combinational; stage metadata advances one stage per clk.
// Backpressure: a load-use hazard raises hazard_stall for one cycle and inserts an EX bubble.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   id_*                - metadata of the instruction currently in ID
//   flush               - taken branch; instruction leaving ID is killed
//   fwd_a_sel/fwd_b_sel - ALU operand mux selects (00 RF, 01 EX/MEM, 10 MEM/WB, 11 zero)
//   hazard_stall        - hold PC and IF/ID this cycle
//   wb_rd/wb_regwrite   - register-file write port control
module forward_ctrl #(
    parameter int          REG_W    = 5,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             hazard_stall,
    output logic [REG_W-1:0] wb_rd,
    output logic             wb_regwrite
);

    localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

    localparam logic [1:0] SEL_RF   = 2'b00;
    localparam logic [1:0] SEL_MEM  = 2'b01;
    localparam logic [1:0] SEL_WB   = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    typedef struct packed {
        logic [REG_W-1:0] rn;
        logic [REG_W-1:0] rm;
        logic [REG_W-1:0] rd;
        logic             rw;
        logic             ld;
    } ex_meta_t;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             rw;
        logic             ld;
    } mem_meta_t;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             rw;
    } wb_meta_t;

    ex_meta_t  ex_q,  ex_d;
    mem_meta_t mem_q, mem_d;
    wb_meta_t  wb_q,  wb_d;

    // Most recent producer wins: MEM is checked before WB. A load sitting in
    // MEM has no data yet, so it never forwards from EX/MEM.
    function automatic logic [1:0] pick_sel(
        input logic [REG_W-1:0] src,
        input mem_meta_t        mem,
        input wb_meta_t         wb
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (src == ZR)
            sel = SEL_ZERO;
        else if (mem.rw && !mem.ld && (mem.rd == src) && (mem.rd != ZR))
            sel = SEL_MEM;
        else if (wb.rw && (wb.rd == src) && (wb.rd != ZR))
            sel = SEL_WB;
        return sel;
    endfunction

    always_comb begin
        fwd_a_sel = pick_sel(ex_q.rn, mem_q, wb_q);
        fwd_b_sel = pick_sel(ex_q.rm, mem_q, wb_q);

        // A flush already kills the dependent instruction, so no stall is needed.
        hazard_stall = id_valid && ex_q.ld && ex_q.rw && (ex_q.rd != ZR) &&
                       ((ex_q.rd == id_rn) || (ex_q.rd == id_rm)) && !flush;

        ex_d = '0;
        if (!(flush || hazard_stall)) begin
            ex_d.rn = id_rn;
            ex_d.rm = id_rm;
            ex_d.rd = id_rd;
            ex_d.rw = id_valid && id_regwrite;
            ex_d.ld = id_valid && id_memread;
        end

        mem_d.rd = ex_q.rd;
        mem_d.rw = ex_q.rw;
        mem_d.ld = ex_q.ld;

        // XZR writes are discarded before they reach the register file.
        wb_d.rd = mem_q.rd;
        wb_d.rw = mem_q.rw && (mem_q.rd != ZR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign wb_rd       = wb_q.rd;
    assign wb_regwrite = wb_q.rw;

endmodule

// File: doc/forward_ctrl.md
Name: forward_ctrl

Overview:
- Pipeline forwarding and hazard controller for the 64-bit 5-stage LEGv8 datapath.
- Tracks destination-register and write-enable metadata through EX, MEM and WB.
- Drives the 2-bit select inputs of the two 64-bit 4:1 operand muxes at the ALU inputs.
- Detects load-use hazards and requests a one-cycle stall, inserting an EX bubble.

Parameters:
- REG_W, 5, register-index width.
- ZERO_REG, 31, index of XZR; reads return zero, writes discarded.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_rn  input  REG_W  first source register of instruction in ID.
- id_rm  input  REG_W  second source register (Rm or Rt for stores) in ID.
- id_rd  input  REG_W  destination register of instruction in ID.
- id_regwrite  input  1  ID instruction writes the register file.
- id_memread  input  1  ID instruction is a load (LDUR).
- flush  input  1  taken branch resolved; the instruction leaving ID is killed.
- fwd_a_sel  output  2  operand-A mux select.
- fwd_b_sel  output  2  operand-B mux select.
- hazard_stall  output  1  hold PC and IF/ID register this cycle.
- wb_rd  output  REG_W  WB destination, to register file.
- wb_regwrite  output  1  WB write enable, to register file.

Behaviour:
- Internal stage registers: ex_{rn,rm,rd,rw,ld}, mem_{rd,rw,ld}, wb_{rd,rw}.
- Select encoding: 00 = register-file read data; 01 = EX/MEM ALU result; 10 = MEM/WB writeback data; 11 = constant zero.
- Reset (synchronous, highest priority): all stage fields cleared to 0, including rw=0 and ld=0.
  - After reset: fwd_a_sel=00, fwd_b_sel=00, hazard_stall=0, wb_regwrite=0, wb_rd=0.
- Each rising edge, in priority order:
  - reset.
  - flush: EX loaded with a bubble (rw=0, ld=0, rn=rm=rd=0).
  - hazard_stall: EX loaded with a bubble.
  - Otherwise: EX loaded from id_* and gated by id_valid (rw and ld forced to 0 when id_valid=0).
  - In all non-reset cases, MEM <- EX and WB <- MEM advance unconditionally.
- fwd_a_sel is combinational from registered state (same rule for fwd_b_sel using ex_rm):
  - ex_rn==ZERO_REG -> 11.
  - Else mem_rw && !mem_ld && mem_rd==ex_rn && mem_rd!=ZERO_REG -> 01.
  - Else wb_rw && wb_rd==ex_rn && wb_rd!=ZERO_REG -> 10.
  - Else 00.
  - MEM match takes priority over WB match, so the most recent producer wins.
- hazard_stall = id_valid && ex_ld && ex_rw && ex_rd!=ZERO_REG && (ex_rd==id_rn || ex_rd==id_rm) && !flush. This is purely combinational, with no added latency.
- A load in MEM is never forwarded via 01 because the stall guarantees a one-cycle gap. If a load in MEM does match, fall through to the WB/00 checks.
- wb_rd and wb_regwrite are direct register outputs. wb_regwrite is forced to 0 when wb_rd==ZERO_REG.
- The register file writes on the falling edge, so an ID read of a register being written in WB needs no forwarding here.
- Simultaneous flush and load-use: flush wins, no stall, EX gets a bubble.
- Reset mid-operation: all in-flight metadata is discarded. No forwarding is produced from pre-reset instructions.

Test Plan:
- ADD X1,X2,X3 followed by SUB X4,X1,X5 -> in SUB's EX cycle fwd_a_sel=01, fwd_b_sel=00.
- ADD X1,… ; unrelated instruction ; ORR X6,X7,X1 -> in ORR's EX cycle fwd_b_sel=10, fwd_a_sel=00.
- ADD X1 ; ADD X1 ; SUB X2,X1,X1 -> both selects 01 (MEM wins over WB).
  - Variant: ADD X31,… ; SUB X2,X31,X3 -> fwd_a_sel=11 and no 01 forward from the X31 writer.
- LDUR X4,[X9] ; ADD X5,X4,X4 -> hazard_stall=1 for exactly one cycle and one bubble in EX; then in ADD's EX cycle fwd_a_sel=fwd_b_sel=10.
- LDUR X4 in EX, dependent instruction in ID, flush=1 in the same cycle -> hazard_stall=0, EX bubble. Next cycle fwd_a_sel=fwd_b_sel=00 with wb_regwrite following the load only.
- Assert reset for one cycle with three writers in flight -> next cycle all selects 00, hazard_stall=0, wb_regwrite=0. The writers never appear at WB.
